// File: rtl/db15_snac_reader.sv
// Serial reader for the DB15 SNAC joystick adapter: drives the load/clock chain,
// samples the data line and publishes one pair of joystick words per frame.
module db15_snac_reader #(
    parameter int CLK_DIV   = 20,
    parameter int NBITS     = 24,
    parameter int GAP_TICKS = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        present,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(NBITS);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int HALF  = NBITS / 2;
    localparam int PBITS = (HALF < 12) ? HALF : 12;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state_q,      state_d;
    logic [DIV_W-1:0]   div_q,        div_d;
    logic [GAP_W-1:0]   gap_q,        gap_d;
    logic [BIT_W-1:0]   bit_idx_q,    bit_idx_d;
    logic [NBITS-1:0]   shreg_q,      shreg_d;
    logic               sync1_q,      sync1_d;
    logic               sync2_q,      sync2_d;
    logic               joy_clk_q,    joy_clk_d;
    logic               joy_load_q,   joy_load_d;
    logic [15:0]        joy1_q,       joy1_d;
    logic [15:0]        joy2_q,       joy2_d;
    logic               present_q,    present_d;
    logic               frame_done_q, frame_done_d;
    logic               tick;

    always_comb begin
        // NOTE: every variable gets its default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        gap_d        = gap_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        joy_clk_d    = joy_clk_q;
        joy_load_d   = joy_load_q;
        joy1_d       = joy1_q;
        joy2_d       = joy2_q;
        present_d    = present_q;
        frame_done_d = 1'b0;
        sync1_d      = JOY_DATA;
        sync2_d      = sync1_q;

        tick = (div_q == DIV_LAST);
        // The divider holds through the single DONE cycle, so the next frame's ticks shift by one cycle.
        if (state_q == S_DONE) begin
            div_d = div_q;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (gap_q == '0) begin
                        joy_load_d = 1'b0;
                        state_d    = S_LOAD;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (tick) begin
                    joy_load_d = 1'b1;
                    bit_idx_d  = '0;
                    state_d    = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    shreg_d[bit_idx_q] = sync2_q;
                    joy_clk_d          = 1'b1;
                    state_d            = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    joy_clk_d = 1'b0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        state_d   = S_LOW;
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                gap_d        = GAP_RELOAD;
                state_d      = S_IDLE;
                joy1_d       = '0;
                joy2_d       = '0;
                present_d    = |shreg_q;
                // An all-zero frame means no adapter: both words stay clear.
                if (|shreg_q) begin
                    for (int i = 0; i < PBITS; i++) begin
                        joy1_d[i] = ~shreg_q[i];
                        joy2_d[i] = ~shreg_q[HALF + i];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: state is updated with non-blocking assignments only, so every flop sees pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            gap_q        <= '0;
            bit_idx_q    <= '0;
            // NOTE: the shift register is a plain flop vector, so it is cleared with the rest of the state.
            shreg_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            joy1_q       <= '0;
            joy2_q       <= '0;
            present_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            gap_q        <= gap_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            joy1_q       <= joy1_d;
            joy2_q       <= joy2_d;
            present_q    <= present_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign JOY_CLK    = joy_clk_q;
    assign JOY_LOAD   = joy_load_q;
    assign joystick1  = joy1_q;
    assign joystick2  = joy2_q;
    assign present    = present_q;
    assign frame_done = frame_done_q;

endmodule
